// File: rtl/if_prefetch_buffer.sv
// rtl/if_prefetch_buffer.sv - instruction prefetch buffer: req/gnt/rvalid fetch port feeding a DEPTH-entry FIFO
// Keeps up to MAX_OUTSTANDING fetches in flight and drops stale responses after a redirect.
module if_prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = CW + OW;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  typedef enum logic [1:0] {BOOT, IDLE, FETCH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     out_addr_q, out_addr_d;
  logic [31:0]     target_q, target_d;
  logic            redir_q, redir_d;
  logic            hold_q, hold_d;
  logic [OW-1:0]   out_q, out_d, out_next;
  logic [OW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_q [DEPTH];

  logic            grant, rvalid_eff, push, pop, slot_free;
  logic [31:0]     branch_tgt, boot_tgt;

  assign branch_tgt = {branch_addr_i[31:2], 2'b00};
  assign boot_tgt   = {boot_addr_i[31:2], 2'b00};

  // A slot is reserved per in-flight request, so every granted word has FIFO room.
  assign slot_free   = (out_q < MAX_OUT) && ((SW'(count_q) + SW'(out_q)) < DEPTH_S);
  assign instr_req_o = (state_q == FETCH) && (hold_q || (fetch_enable_i && slot_free));
  assign instr_addr_o = req_addr_q;

  assign grant      = instr_req_o && instr_gnt_i;
  assign rvalid_eff = instr_rvalid_i && (out_q != '0);
  assign push       = rvalid_eff && (discard_q == '0) && !branch_i;
  assign pop        = fetch_valid_o && fetch_ready_i && !branch_i;

  assign fetch_valid_o = (count_q != '0);
  assign fetch_rdata_o = fetch_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fetch_addr_o  = out_addr_q;
  assign busy_o        = (out_q != '0) || fetch_valid_o || instr_req_o;

  always_comb begin
    out_next = out_q;
    if (grant && !rvalid_eff) begin
      out_next = out_q + OW'(1);
    end else if (!grant && rvalid_eff) begin
      out_next = out_q - OW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    out_addr_d = out_addr_q;
    target_d   = target_q;
    redir_d    = redir_q;
    hold_d     = instr_req_o && !instr_gnt_i;
    out_d      = out_next;
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    unique case (state_q)
      BOOT: begin
        req_addr_d = boot_tgt;
        out_addr_d = boot_tgt;
        state_d    = IDLE;
      end
      IDLE:    if (fetch_enable_i) state_d = FETCH;
      FETCH:   if (!fetch_enable_i && !hold_d) state_d = IDLE;
      default: state_d = BOOT;
    endcase

    if (rvalid_eff && (discard_q != '0)) discard_d = discard_q - OW'(1);

    if (grant) begin
      // A request held across a redirect fetches a dead word; then jump to the target.
      if (redir_q) begin
        req_addr_d = target_q;
        redir_d    = 1'b0;
        discard_d  = discard_d + OW'(1);
      end else begin
        req_addr_d = req_addr_q + 32'd4;
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      out_addr_d = out_addr_q + 32'd4;
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (branch_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      out_addr_d = branch_tgt;
      target_d   = branch_tgt;
      discard_d  = out_next;
      if (hold_d) begin
        redir_d    = 1'b1;
        req_addr_d = req_addr_q;
      end else begin
        redir_d    = 1'b0;
        req_addr_d = branch_tgt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      req_addr_q <= '0;
      out_addr_q <= '0;
      target_q   <= '0;
      redir_q    <= 1'b0;
      hold_q     <= 1'b0;
      out_q      <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      out_addr_q <= out_addr_d;
      target_q   <= target_d;
      redir_q    <= redir_d;
      hold_q     <= hold_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= instr_rdata_i;
  end

endmodule
